// File: rtl/pipe_pkg.sv
// Shared RV32I pipeline decode helpers: opcodes, field extraction and the
// load-interlock state encoding.
package pipe_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OPC_W  = 7;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        MEMWAIT
    } ilk_state_t;

    function automatic logic [REG_W-1:0] rd(input logic [INSN_W-1:0] ir);
        return ir[11:7];
    endfunction

    function automatic logic [REG_W-1:0] rs1(input logic [INSN_W-1:0] ir);
        return ir[19:15];
    endfunction

    function automatic logic [REG_W-1:0] rs2(input logic [INSN_W-1:0] ir);
        return ir[24:20];
    endfunction

    function automatic logic is_load(input logic [INSN_W-1:0] ir);
        return ir[6:0] == OP_LOAD;
    endfunction

    function automatic logic is_nop(input logic [INSN_W-1:0] ir);
        return (ir == '0) || (ir == NOP_INSN);
    endfunction

    function automatic logic uses_rs1(input logic [INSN_W-1:0] ir);
        return !((ir[6:0] == OP_LUI) || (ir[6:0] == OP_AUIPC) || (ir[6:0] == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [INSN_W-1:0] ir);
        return (ir[6:0] == OP_OP) || (ir[6:0] == OP_STORE) || (ir[6:0] == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between ID/EX (producer load) and
// IF/ID (consumer).
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [INSN_W-1:0] id_ex_ir,
    input  logic              id_ex_valid,
    input  logic [INSN_W-1:0] if_id_ir,
    input  logic              if_id_valid,
    output logic              hit_c,
    output logic [REG_W-1:0]  load_rd_c
);

    logic src_match;

    always_comb begin
        load_rd_c = rd(id_ex_ir);
        src_match = (uses_rs1(if_id_ir) && (rs1(if_id_ir) == load_rd_c)) ||
                    (uses_rs2(if_id_ir) && (rs2(if_id_ir) == load_rd_c));
        hit_c     = id_ex_valid && if_id_valid && is_load(id_ex_ir) &&
                    (load_rd_c != '0) && !is_nop(id_ex_ir) && !is_nop(if_id_ir) &&
                    src_match;
    end

endmodule

// File: rtl/load_interlock_ctrl.sv
// Load-use interlock: holds the front end for LOAD_LAT cycles per hazard,
// optionally extended until mem_ready, with a saturating stall counter.
module load_interlock_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_LAT      = 1,
    parameter int unsigned USE_MEM_READY = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INSN_W-1:0] if_id_ir,
    input  logic              if_id_valid,
    input  logic [INSN_W-1:0] id_ex_ir,
    input  logic              id_ex_valid,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              stall,
    output logic              bubble,
    output logic [REG_W-1:0]  hazard_rd,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned LAT_W = 3;

    ilk_state_t       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] pending_rd_q, pending_rd_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic             hit_c;
    logic [REG_W-1:0] load_rd_c;
    logic             mem_wait_c;

    hazard_detect u_hazard_detect (
        .id_ex_ir    (id_ex_ir),
        .id_ex_valid (id_ex_valid),
        .if_id_ir    (if_id_ir),
        .if_id_valid (if_id_valid),
        .hit_c       (hit_c),
        .load_rd_c   (load_rd_c)
    );

    assign mem_wait_c = (USE_MEM_READY != 0) && !mem_ready;

    // Next-state and stall outputs; stall must react in the same cycle as hit.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_rd_d = pending_rd_q;
        stall        = 1'b0;
        hazard_rd    = '0;

        unique case (state_q)
            IDLE: begin
                stall     = hit_c;
                hazard_rd = hit_c ? load_rd_c : '0;
                if (hit_c) begin
                    pending_rd_d = load_rd_c;
                    if (LOAD_LAT > 1) begin
                        cnt_d   = LAT_W'(LOAD_LAT - 1);
                        state_d = COUNT;
                    end else if (mem_wait_c) begin
                        state_d = MEMWAIT;
                    end
                end
            end
            COUNT: begin
                stall     = 1'b1;
                hazard_rd = pending_rd_q;
                cnt_d     = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    state_d = mem_wait_c ? MEMWAIT : IDLE;
                end
            end
            MEMWAIT: begin
                stall     = !mem_ready;
                hazard_rd = pending_rd_q;
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect kills the dependent pair, so any wait in progress is void.
        if (flush) begin
            stall        = 1'b0;
            state_d      = IDLE;
            cnt_d        = '0;
            pending_rd_d = '0;
        end

        bubble = stall;

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pending_rd_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_rd_q   <= pending_rd_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_interlock_ctrl.sv
// Randomised plus directed bench for load_interlock_ctrl across four parameter
// sets, checked against a cycle-level behavioural model.
module tb_load_interlock_ctrl;

    localparam int NI = 4;

    localparam logic [31:0] LW5  = 32'h0000A283;
    localparam logic [31:0] ADD  = 32'h00728333;
    localparam logic [31:0] SW   = 32'h00512023;
    localparam logic [31:0] LW0  = 32'h0000A003;
    localparam logic [31:0] ADD0 = 32'h00000333;
    localparam logic [31:0] LUI  = 32'h000283B7;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_id_ir, id_ex_ir;
    logic        if_id_valid, id_ex_valid, flush, mem_ready;

    logic        st [NI];
    logic        bb [NI];
    logic [4:0]  hr [NI];
    logic [15:0] sc0, sc1, sc2;
    logic [3:0]  sc3;

    int n_vec = 0;
    int n_err = 0;

    // Model: remaining fixed stall cycles, memory-wait phase, held rd, count.
    int         rem  [NI];
    bit         memw [NI];
    logic [4:0] prd  [NI];
    int         cnt  [NI];

    always #5 clk = ~clk;

    load_interlock_ctrl #(.LOAD_LAT(1), .USE_MEM_READY(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .if_id_valid(if_id_valid),
        .id_ex_ir(id_ex_ir), .id_ex_valid(id_ex_valid), .flush(flush), .mem_ready(mem_ready),
        .stall(st[0]), .bubble(bb[0]), .hazard_rd(hr[0]), .stall_cycles(sc0));
    load_interlock_ctrl #(.LOAD_LAT(3), .USE_MEM_READY(0), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .if_id_valid(if_id_valid),
        .id_ex_ir(id_ex_ir), .id_ex_valid(id_ex_valid), .flush(flush), .mem_ready(mem_ready),
        .stall(st[1]), .bubble(bb[1]), .hazard_rd(hr[1]), .stall_cycles(sc1));
    load_interlock_ctrl #(.LOAD_LAT(2), .USE_MEM_READY(1), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .if_id_valid(if_id_valid),
        .id_ex_ir(id_ex_ir), .id_ex_valid(id_ex_valid), .flush(flush), .mem_ready(mem_ready),
        .stall(st[2]), .bubble(bb[2]), .hazard_rd(hr[2]), .stall_cycles(sc2));
    load_interlock_ctrl #(.LOAD_LAT(3), .USE_MEM_READY(1), .CNT_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .if_id_valid(if_id_valid),
        .id_ex_ir(id_ex_ir), .id_ex_valid(id_ex_valid), .flush(flush), .mem_ready(mem_ready),
        .stall(st[3]), .bubble(bb[3]), .hazard_rd(hr[3]), .stall_cycles(sc3));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit mr_of(input int k);
        return k >= 2;
    endfunction

    function automatic int max_of(input int k);
        return (k == 3) ? 15 : 65535;
    endfunction

    function automatic logic [31:0] sc_of(input int k);
        case (k)
            0:       return {16'd0, sc0};
            1:       return {16'd0, sc1};
            2:       return {16'd0, sc2};
            default: return {28'd0, sc3};
        endcase
    endfunction

    // Decode straight from the RV32I operand-usage rules.
    function automatic bit ref_hit(input logic [31:0] ex, input logic exv,
                                   input logic [31:0] id, input logic idv);
        logic [4:0] d;
        logic [6:0] op;
        bit r1, r2;
        if (!exv || !idv) return 0;
        if (ex[6:0] != 7'h03) return 0;
        if (id == 32'h0 || id == NOP) return 0;
        d  = ex[11:7];
        if (d == 5'd0) return 0;
        op = id[6:0];
        r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        r2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return (r1 && id[19:15] == d) || (r2 && id[24:20] == d);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            rem[k] = 0; memw[k] = 0; prd[k] = '0; cnt[k] = 0;
        end
    endtask

    task automatic drive(input logic [31:0] ex, input logic exv, input logic [31:0] id,
                         input logic idv, input logic fl, input logic mr);
        id_ex_ir = ex; id_ex_valid = exv; if_id_ir = id; if_id_valid = idv;
        flush = fl; mem_ready = mr;
    endtask

    // Called just after a falling edge with inputs applied; checks, advances one clock.
    task automatic step();
        bit         h, busy, es;
        logic [4:0] erd;
        #2;
        h = ref_hit(id_ex_ir, id_ex_valid, if_id_ir, if_id_valid);
        for (int k = 0; k < NI; k++) begin
            busy = (rem[k] > 0) || memw[k];
            if (!busy) begin
                es  = h && !flush;
                erd = h ? id_ex_ir[11:7] : 5'd0;
            end else if (rem[k] > 0) begin
                es  = !flush;
                erd = prd[k];
            end else begin
                es  = !mem_ready && !flush;
                erd = prd[k];
            end
            check($sformatf("stall%0d", k), {31'd0, st[k]}, {31'd0, es});
            check($sformatf("bubble%0d", k), {31'd0, bb[k]}, {31'd0, es});
            check($sformatf("hazard_rd%0d", k), {27'd0, hr[k]}, {27'd0, erd});
            check($sformatf("stall_cycles%0d", k), sc_of(k), cnt[k]);
            if (flush) begin
                rem[k] = 0; memw[k] = 0; prd[k] = '0;
            end else if (!busy) begin
                if (h) begin
                    prd[k] = id_ex_ir[11:7];
                    rem[k] = lat_of(k) - 1;
                    if (rem[k] == 0 && mr_of(k) && !mem_ready) memw[k] = 1;
                end
            end else if (rem[k] > 0) begin
                rem[k]--;
                if (rem[k] == 0 && mr_of(k) && !mem_ready) memw[k] = 1;
            end else if (mem_ready) begin
                memw[k] = 0;
            end
            if (es && cnt[k] < max_of(k)) cnt[k]++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_stall%0d", k), {31'd0, st[k]}, 32'd0);
            check($sformatf("rst_hazard_rd%0d", k), {27'd0, hr[k]}, 32'd0);
            check($sformatf("rst_stall_cycles%0d", k), sc_of(k), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_steps(input int n, input logic mr);
        drive(NOP, 1'b1, NOP, 1'b1, 1'b0, mr);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] rnd_insn();
        logic [6:0] ops [9];
        logic [6:0] op;
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h63; ops[3] = 7'h33; ops[4] = 7'h37;
        ops[5] = 7'h17; ops[6] = 7'h6F; ops[7] = 7'h13; ops[8] = 7'h67;
        op = ops[$urandom_range(8)];
        if ($urandom_range(15) == 0) return NOP;
        return {7'd0, 5'($urandom_range(3)), 5'($urandom_range(3)), 3'b010,
                5'($urandom_range(3)), op};
    endfunction

    initial begin
        logic [31:0] ex;
        rst_n = 1'b0;
        drive(NOP, 1'b0, NOP, 1'b0, 1'b0, 1'b1);
        model_reset();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_stall%0d", k), {31'd0, st[k]}, 32'd0);
            check($sformatf("reset_stall_cycles%0d", k), sc_of(k), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load-use via rs1, then via store rs2
        drive(LW5, 1'b1, ADD, 1'b1, 1'b0, 1'b1); step();
        idle_steps(4, 1'b1);
        drive(LW5, 1'b1, SW, 1'b1, 1'b0, 1'b1);  step();
        idle_steps(4, 1'b1);

        // No-hazard pairs
        drive(LW0, 1'b1, ADD0, 1'b1, 1'b0, 1'b1); step();
        drive(LW5, 1'b1, LUI, 1'b1, 1'b0, 1'b1);  step();
        drive(LW5, 1'b0, ADD, 1'b1, 1'b0, 1'b1);  step();
        drive(LW5, 1'b1, ADD, 1'b0, 1'b0, 1'b1);  step();
        idle_steps(1, 1'b1);

        // Memory-ready extension
        drive(LW5, 1'b1, ADD, 1'b1, 1'b0, 1'b0); step();
        idle_steps(5, 1'b0);
        idle_steps(3, 1'b1);

        // Flush in the second stall cycle, then a fresh hazard
        drive(LW5, 1'b1, ADD, 1'b1, 1'b0, 1'b1); step();
        drive(NOP, 1'b1, NOP, 1'b1, 1'b1, 1'b1); step();
        idle_steps(2, 1'b1);
        drive(LW5, 1'b1, ADD, 1'b1, 1'b0, 1'b1); step();
        idle_steps(4, 1'b1);

        // Async reset while waiting on memory
        drive(LW5, 1'b1, ADD, 1'b1, 1'b0, 1'b0); step();
        idle_steps(2, 1'b0);
        async_reset();

        // Drive the narrow counter into saturation
        drive(LW5, 1'b1, ADD, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) step();
        idle_steps(4, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            ex = ($urandom_range(1) == 1) ?
                 {20'h00000 | 20'($urandom_range(3) << 15), 5'd2, 5'($urandom_range(3)), 7'h03} :
                 rnd_insn();
            drive(ex, 1'($urandom_range(7) != 0), rnd_insn(), 1'($urandom_range(7) != 0),
                  1'($urandom_range(11) == 0), 1'($urandom_range(4) < 3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
